// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the core's memory stage and the
// word-addressed data memory (Dm).
//
// Stores from the core are queued in a circular array of {addr, data, pc}
// entries. The buffer drains them in program order, one per cycle, into the
// Dm write port. Loads look up the queued stores combinationally and get
// forwarded data from the youngest matching entry, so a load never sees stale
// memory contents.
//
// Optional feature (compile-time macro STORE_BUFFER_COALESCE_EN):
//   A store whose word address matches the youngest valid entry merges into
//   that entry instead of allocating a new one. This does not apply when the
//   youngest entry is also the head being popped this cycle.
//
// Parameters:
//   DEPTH  number of buffered stores (power of two, >= 2)
//   AW     address width (matching/draining use addr[AW-1:2])
//   DW     data width
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   st_valid/addr/data/pc, st_ready   store push handshake from the core
//   ld_addr, ld_hit, ld_data          combinational load-forwarding lookup
//   drain_hold                        inhibits draining this cycle
//   dm_wEn/addr/dIn/pc                Dm write port (head entry)
//   count, empty                      occupancy status
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    input  logic [31:0]              st_pc,
    output logic                     st_ready,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_hit,
    output logic [DW-1:0]            ld_data,
    input  logic                     drain_hold,
    output logic                     dm_wEn,
    output logic [AW-1:0]            dm_addr,
    output logic [DW-1:0]            dm_dIn,
    output logic [31:0]              dm_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = AW - 2;

    // Entry storage: word address only, the byte offset is never needed.
    logic [WW-1:0]  entAddr [DEPTH];
    logic [DW-1:0]  entData [DEPTH];
    logic [31:0]    entPc   [DEPTH];

    logic [PW-1:0]  headPtr;
    logic [PW-1:0]  tailPtr;

    logic           drainEn;
    logic           pushEn;
    logic           allocEn;
    logic           coalesceMatch;
    logic           fwdHit;
    logic [DW-1:0]  fwdData;
    logic [PW-1:0]  fwdIdx;

    // Byte-offset bits are deliberately ignored by the word-addressed memory.
    logic           unusedOffsetBits;
    assign unusedOffsetBits = ^{st_addr[1:0], ld_addr[1:0]};

    assign empty   = (count == CW'(0));
    assign drainEn = ~empty & ~drain_hold;
    assign dm_wEn  = drainEn;

`ifdef STORE_BUFFER_COALESCE_EN
    logic [PW-1:0]  youngIdx;
    assign youngIdx = tailPtr - PW'(1);
    // The youngest entry cannot absorb a store while it is leaving as the head.
    assign coalesceMatch = ~empty
                         & (entAddr[youngIdx] == st_addr[AW-1:2])
                         & ~(drainEn & (count == CW'(1)));
`else
    assign coalesceMatch = 1'b0;
`endif

    // A full buffer still accepts when a slot frees this cycle or the store merges.
    assign st_ready = (count < CW'(DEPTH)) | drainEn | coalesceMatch;
    assign pushEn   = st_valid & st_ready;
    assign allocEn  = pushEn & ~coalesceMatch;

    // Head entry drives the Dm port; zeros when nothing is buffered.
    assign dm_addr = empty ? '0 : {entAddr[headPtr], 2'b00};
    assign dm_dIn  = empty ? '0 : entData[headPtr];
    assign dm_pc   = empty ? '0 : entPc[headPtr];

    // Forwarding lookup: walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        fwdIdx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwdIdx = headPtr + i[PW-1:0];
            if ((CW'(i) < count) && (entAddr[fwdIdx] == ld_addr[AW-1:2])) begin
                fwdHit  = 1'b1;
                fwdData = entData[fwdIdx];
            end else begin
                fwdHit  = fwdHit;
                fwdData = fwdData;
            end
        end
    end

    assign ld_hit  = fwdHit;
    assign ld_data = fwdData;

    // Pointers and occupancy; count only moves when exactly one of alloc/pop fires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (allocEn) begin
                tailPtr <= tailPtr + PW'(1);
            end
            if (drainEn) begin
                headPtr <= headPtr + PW'(1);
            end
            case ({allocEn, drainEn})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry array: allocate at tail, or merge into the youngest entry when coalescing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entAddr[i] <= '0;
                entData[i] <= '0;
                entPc[i]   <= '0;
            end
        end else begin
            if (allocEn) begin
                entAddr[tailPtr] <= st_addr[AW-1:2];
                entData[tailPtr] <= st_data;
                entPc[tailPtr]   <= st_pc;
            end
`ifdef STORE_BUFFER_COALESCE_EN
            else if (pushEn) begin
                entData[youngIdx] <= st_data;
                entPc[youngIdx]   <= st_pc;
            end
`endif
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a scoreboard of expected Dm writes.
// Accepted stores are queued when the handshake completes; every Dm write is
// popped and compared. Build with STORE_BUFFER_COALESCE_EN to exercise merging.
module tb_store_buffer;

    localparam int DEPTH = 4;
`ifdef STORE_BUFFER_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc;
    logic        st_ready;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        drain_hold;
    logic        dm_wEn;
    logic [31:0] dm_addr;
    logic [31:0] dm_dIn;
    logic [31:0] dm_pc;
    logic [2:0]  count;
    logic        empty;

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_pc      (st_pc),
        .st_ready   (st_ready),
        .ld_addr    (ld_addr),
        .ld_hit     (ld_hit),
        .ld_data    (ld_data),
        .drain_hold (drain_hold),
        .dm_wEn     (dm_wEn),
        .dm_addr    (dm_addr),
        .dm_dIn     (dm_dIn),
        .dm_pc      (dm_pc),
        .count      (count),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    ent_t q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   writes = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard model state, used only by the monitor process.
    int   sz;
    bit   expW;
    bit   coalM;
    bit   expReady;
    ent_t e;

    always @(negedge reset) q.delete();

    // Monitor: compare status and Dm writes against the model, then update the model.
    always @(negedge clk) begin
        if (reset) begin
            sz       = q.size();
            expW     = (sz != 0) && !drain_hold;
            coalM    = COAL && (sz != 0) && (q[sz-1].a[31:2] == st_addr[31:2]) && !(expW && sz == 1);
            expReady = (sz < DEPTH) || expW || coalM;
            chk("mon_count", 64'(count), 64'(sz));
            chk("mon_empty", 64'(empty), 64'(sz == 0));
            chk("mon_st_ready", 64'(st_ready), 64'(expReady));
            chk("mon_dm_wEn", 64'(dm_wEn), 64'(expW));
            if (expW) begin
                e = q.pop_front();
                chk("dm_addr", 64'(dm_addr), 64'({e.a[31:2], 2'b00}));
                chk("dm_dIn", 64'(dm_dIn), 64'(e.d));
                chk("dm_pc", 64'(dm_pc), 64'(e.p));
                writes++;
            end else if (sz == 0) begin
                chk("dm_zero", 64'({dm_addr, dm_dIn}), 64'(0));
            end
            if (st_valid && expReady) begin
                if (coalM) begin
                    q[q.size()-1].d = st_data;
                    q[q.size()-1].p = st_pc;
                end else begin
                    e.a = st_addr;
                    e.d = st_data;
                    e.p = st_pc;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pushStore(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        bit rdy;
        bit done;
        done     = 1'b0;
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_pc    = p;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            rdy = st_ready;
            cyc();
            done = rdy;
        end
        chk("push_accepted", 64'(done), 64'(1));
        st_valid = 1'b0;
    endtask

    task automatic waitEmpty(input int limit);
        int n;
        n = 0;
        while (!empty && n < limit) begin
            cyc();
            n++;
        end
        chk("drain_done", 64'(empty), 64'(1));
    endtask

    int wr0;

    initial begin
        reset      = 1'b0;
        st_valid   = 1'b0;
        st_addr    = 32'h0;
        st_data    = 32'h0;
        st_pc      = 32'h0;
        ld_addr    = 32'h0;
        drain_hold = 1'b0;
        cyc();

        // Reset state
        chk("rst_st_ready", 64'(st_ready), 64'(1));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_dm_wEn", 64'(dm_wEn), 64'(0));
        chk("rst_ld", 64'({ld_hit, ld_data}), 64'(0));
        chk("rst_dm", 64'({dm_addr, dm_pc}), 64'(0));
        reset = 1'b1;
        cyc();

        // Single store drains on the following cycle
        pushStore(32'h10, 32'hAAAA0001, 32'h3000);
        chk("t1_wEn", 64'(dm_wEn), 64'(1));
        chk("t1_addr", 64'(dm_addr), 64'(32'h10));
        chk("t1_dIn", 64'(dm_dIn), 64'(32'hAAAA0001));
        chk("t1_pc", 64'(dm_pc), 64'(32'h3000));
        cyc();
        chk("t1_empty", 64'(empty), 64'(1));

        // Fill under hold, fifth store waits for release
        drain_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pushStore(32'(4 * i), 32'hB0 + 32'(i), 32'h3100 + 32'(4 * i));
        end
        chk("t2_count_full", 64'(count), 64'(4));
        chk("t2_not_ready", 64'(st_ready), 64'(0));
        st_valid = 1'b1;
        st_addr  = 32'h10;
        st_data  = 32'hB5;
        st_pc    = 32'h3110;
        repeat (3) cyc();
        chk("t2_still_blocked", 64'(st_ready), 64'(0));
        chk("t2_count_held", 64'(count), 64'(4));
        drain_hold = 1'b0;
        #1;
        chk("t2_ready_on_drain", 64'(st_ready), 64'(1));
        cyc();
        st_valid = 1'b0;
        chk("t2_count_after", 64'(count), 64'(4));
        waitEmpty(20);

        // Forwarding: youngest match wins, pushed store invisible until the edge
        drain_hold = 1'b1;
        pushStore(32'h20, 32'h11, 32'h3200);
        pushStore(32'h20, 32'h22, 32'h3204);
        pushStore(32'h28, 32'h33, 32'h3208);
        ld_addr = 32'h23;
        #1;
        chk("fwd_hit", 64'(ld_hit), 64'(1));
        chk("fwd_young", 64'(ld_data), 64'(32'h22));
        ld_addr = 32'h24;
        #1;
        chk("fwd_miss", 64'({ld_hit, ld_data}), 64'(0));
        ld_addr = 32'h28;
        #1;
        chk("fwd_other", 64'(ld_data), 64'(32'h33));
        st_valid = 1'b1;
        st_addr  = 32'h30;
        st_data  = 32'h44;
        st_pc    = 32'h320C;
        ld_addr  = 32'h30;
        #1;
        chk("fwd_no_bypass", 64'(ld_hit), 64'(0));
        cyc();
        st_valid = 1'b0;
        chk("fwd_after_edge", 64'({ld_hit, ld_data}), 64'({1'b1, 32'h44}));
        drain_hold = 1'b0;
        ld_addr    = 32'h20;
        #1;
        chk("fwd_while_pop", 64'(ld_data), 64'(32'h22));
        waitEmpty(20);

        // Full buffer with concurrent push and pop across pointer wrap
        drain_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pushStore(32'h50 + 32'(4 * i), 32'hC0 + 32'(i), 32'h3300 + 32'(4 * i));
        end
        drain_hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pushStore(32'h60 + 32'(4 * i), 32'hD0 + 32'(i), 32'h3400 + 32'(4 * i));
            chk("t4_count_steady", 64'(count), 64'(4));
        end
        waitEmpty(20);

        // Asynchronous reset mid-cycle discards pending stores
        drain_hold = 1'b1;
        pushStore(32'h70, 32'hE0, 32'h3500);
        pushStore(32'h74, 32'hE1, 32'h3504);
        pushStore(32'h78, 32'hE2, 32'h3508);
        chk("t5_count3", 64'(count), 64'(3));
        drain_hold = 1'b0;
        ld_addr    = 32'h70;
        #1;
        reset = 1'b0;
        #1;
        chk("t5_count0", 64'(count), 64'(0));
        chk("t5_no_wEn", 64'(dm_wEn), 64'(0));
        chk("t5_empty", 64'({empty, st_ready}), 64'(2'b11));
        chk("t5_no_hit", 64'(ld_hit), 64'(0));
        #1;
        reset = 1'b1;
        wr0 = writes;
        repeat (5) cyc();
        chk("t5_no_writes", 64'(writes), 64'(wr0));
        chk("t5_count_stays", 64'(count), 64'(0));

        // Same-address stores: merge when coalescing, two writes otherwise
        drain_hold = 1'b1;
        wr0 = writes;
        pushStore(32'h40, 32'h1, 32'h3600);
        pushStore(32'h40, 32'h2, 32'h3604);
        chk("t6_count", 64'(count), COAL ? 64'(1) : 64'(2));
        drain_hold = 1'b0;
        waitEmpty(20);
        chk("t6_writes", 64'(writes - wr0), COAL ? 64'(1) : 64'(2));

        chk("sb_drained", 64'(q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO between the core's memory stage and the word-addressed data memory (Dm).
- Accepts word stores from the core and drains them one per cycle into the Dm write port (wEn/addr/dIn/pc).
- Serves youngest-match forwarding to loads, so reads never return stale data.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- AW, 32, address width; matching and draining use word address addr[AW-1:2].
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- st_valid  input  1  core presents a store this cycle.
- st_addr  input  AW  store byte address; bits [1:0] ignored.
- st_data  input  DW  store data.
- st_pc  input  32  PC of the store instruction, carried to Dm for its write log.
- st_ready  output  1  buffer can accept a store this cycle.
- ld_addr  input  AW  load byte address from the core (combinational lookup).
- ld_hit  output  1  a buffered store matches ld_addr[AW-1:2].
- ld_data  output  DW  data of the youngest matching entry; 0 when ld_hit=0.
- drain_hold  input  1  inhibits draining this cycle.
- dm_wEn  output  1  write enable to Dm.
- dm_addr  output  AW  word-aligned address to Dm ({head_addr[AW-1:2],2'b00}).
- dm_dIn  output  DW  write data to Dm.
- dm_pc  output  32  PC of the head entry.
- count  output  log2(DEPTH)+1  number of valid entries.
- empty  output  1  count==0.

Behaviour:
- Storage: circular array of DEPTH entries {addr, data, pc}, with head/tail pointers of log2(DEPTH) bits (natural wrap) and a separate count register.
- Reset (reset==0, asynchronous): count=0, head=tail=0, all entries cleared.
  - All outputs are 0 except st_ready=1 and empty=1.
  - Pending stores are discarded, including one mid-drain; no Dm write occurs while reset is low.
- st_ready = (count<DEPTH) | dm_wEn.
  - A full buffer accepts a store in the same cycle it drains.
- Push: st_valid & st_ready writes the entry at tail, tail+1.
  - Store with st_ready=0 is ignored; the core must hold st_valid and the operands stable until st_ready.
- Drain: dm_wEn = ~empty & ~drain_hold (combinational).
  - dm_addr/dm_dIn/dm_pc are taken from the head entry; all are 0 when empty.
  - On the rising edge with dm_wEn=1, Dm commits the write and the buffer pops (head+1).
- Simultaneous push and pop: count is unchanged, both pointers advance.
  - Push into an empty buffer is never bypassed to Dm in the same cycle.
- Latency: a store accepted at edge N is visible on dm_* after N and is written at edge N+1 at the earliest, absent hold and older entries.
- Order: strict FIFO; Dm sees writes in program order.
- Forwarding: compare ld_addr[AW-1:2] against every valid entry; the youngest match (nearest tail) wins.
  - The lookup is purely combinational.
  - An entry popping this cycle still counts as valid until the edge.
  - A store being pushed this cycle is not visible to ld_* until after the edge.
- count is derived so that it never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: STORE_BUFFER_COALESCE_EN.
- Defined: an accepted store whose word address equals the youngest valid entry's, where that entry is not also head-popping this cycle, overwrites that entry's data and pc instead of allocating.
  - count and tail are unchanged.
  - A coalesced store is accepted even when full, so st_ready = (count<DEPTH) | dm_wEn | coalesce_match.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset, then push addr 0x10/data 0xAAAA0001/pc 0x3000 with drain_hold=0 -> next cycle dm_wEn=1, dm_addr=0x10, dm_dIn=0xAAAA0001, dm_pc=0x3000; following cycle empty=1.
- drain_hold=1, push 4 stores to 0x0,0x4,0x8,0xC -> count=4, st_ready=0; fifth store held until release; release hold -> Dm writes in order 0x0,0x4,0x8,0xC, then the fifth.
- With hold=1, buffer holding 0x20←0x11 then 0x20←0x22, ld_addr=0x23 -> ld_hit=1, ld_data=0x22; ld_addr=0x24 -> ld_hit=0, ld_data=0.
- Full buffer, hold=0, push same cycle -> accepted, count stays 4, pointers wrap correctly over 10 further push/pop cycles.
- Three entries queued, reset pulsed low mid-cycle (asynchronous) -> count=0 and dm_wEn=0 immediately; no further Dm writes after release.
- STORE_BUFFER_COALESCE_EN defined, hold=1, push 0x40←1 then 0x40←2 -> count=1, drain gives a single write 0x40←2; macro undefined -> count=2, two writes.
